// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline skid register family.
//
//   Contents:
//     PIPE_DEFAULT_WIDTH : default data word width for pipeline stages.
//     pipe_state_e       : occupancy state of a one-entry skid stage.
//                          EMPTY : no word held
//                          ONE   : one word in the main register
//                          FULL  : main register plus skid register occupied
//                          The fourth 2-bit code is illegal and recovers to EMPTY.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// pipe_sat_counter
//   Saturating up-counter with enable and asynchronous active-low clear.
//   Counts by one on each rising clock edge where en=1 and sticks at the
//   all-ones value.
//
//   Parameters:
//     WIDTH : counter width in bits (>= 1)
//
//   Ports:
//     clk   in   1      rising-edge clock
//     rst_n in   1      asynchronous active-low clear
//     en    in   1      count enable
//     count out  WIDTH  current count
// -----------------------------------------------------------------------------
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Pipeline stage register with valid/ready handshake and a one-entry skid
//   buffer. in_ready is decoded from registered state only, so there is no
//   combinational path from out_ready back to in_ready. Words leave in strict
//   acceptance order with one cycle of latency; a stalled downstream never
//   causes a word to be dropped or duplicated.
//
//   Build option:
//     SKID_STATS_EN : when defined, adds the stall_count output, a saturating
//                     count of edges where out_valid=1 and out_ready=0.
//                     Cleared only by reset_n.
//
//   Parameters:
//     WIDTH      : data word width (>= 1)
//     STAT_WIDTH : stall counter width (>= 2), meaningful with SKID_STATS_EN
//
//   Ports:
//     clock       in   1           rising-edge clock
//     reset_n     in   1           asynchronous active-low reset
//     flush       in   1           synchronous discard of all buffered words
//     in_data     in   WIDTH       upstream word
//     in_valid    in   1           upstream word present
//     in_ready    out  1           stage can accept a word this cycle
//     out_data    out  WIDTH       downstream word
//     out_valid   out  1           out_data holds a valid word
//     out_ready   in   1           downstream accepts out_data this cycle
//     stall_count out  STAT_WIDTH  (SKID_STATS_EN only) stall edge counter
// -----------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH      = PIPE_DEFAULT_WIDTH,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SKID_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stall_count
`endif
);

  // Reject nonsensical configurations at elaboration time.
  if ((WIDTH < 1) || (STAT_WIDTH < 2)) begin : g_bad_param
    $error("pipe_skid_reg: WIDTH must be >= 1 and STAT_WIDTH >= 2");
  end

  pipe_state_e      state_q;
  pipe_state_e      state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Flush wins over every handshake in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) state_d = ONE;
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d = FULL;
          end else if (!in_xfer && out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from registered state only. Illegal encodings present
  // neither valid nor ready, so nothing is accepted or emitted while they
  // recover to EMPTY.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = reset_n & ((state_q == EMPTY) | (state_q == ONE));
    out_valid = (state_q == ONE) | (state_q == FULL);
    out_data  = main_q;
  end

  // ---------------------------------------------------------------------------
  // Data path. Registers load only on an accepted word, so in_data seen while
  // in_valid=0 can never become a valid output. On flush the contents are left
  // as they are; state alone marks them dead.
  // ---------------------------------------------------------------------------
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) main_d = in_data;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            // Downstream stalled: park the new word behind the one on display.
            skid_d = in_data;
          end
        end
        FULL: begin
          if (out_xfer) main_d = skid_q;
        end
        default: begin
          main_d = main_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef SKID_STATS_EN
  // ---------------------------------------------------------------------------
  // Stall statistics: counts edges where a word waits on the downstream.
  // ---------------------------------------------------------------------------
  logic stall_en;

  assign stall_en = out_valid & ~out_ready;

  pipe_sat_counter #(
    .WIDTH (STAT_WIDTH)
  ) u_stall_cnt (
    .clk   (clock),
    .rst_n (reset_n),
    .en    (stall_en),
    .count (stall_count)
  );
`endif

endmodule : pipe_skid_reg
